mem_axi_master: RTL and testbench
=================================

# mem_axi_master

Load/store front end that converts single core memory requests into AXI4-Lite master transactions. It drives the block-RAM AXI4-Lite slave (and any other slave on the same bus) and returns aligned, sign/zero-extended load data to the core's memory stage. It keeps one transaction in flight and provides byte-lane steering, write strobes and misalignment detection.

## Interface
Parameters:
- none (address and data widths fixed at 32)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (high iff state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (low bits used for byte/half)
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or AXI xRESP[1] set
- axi_araddr / axi_arvalid / axi_arprot  out  32/1/3  read address channel
- axi_arready  in  1
- axi_rdata / axi_rresp / axi_rvalid  in  32/2/1  read data channel
- axi_rready  out  1
- axi_awaddr / axi_awvalid / axi_awprot  out  32/1/3  write address channel
- axi_awready  in  1
- axi_wdata / axi_wstrb / axi_wvalid  out  32/4/1  write data channel
- axi_wready  in  1
- axi_bresp / axi_bvalid  in  2/1  write response channel
- axi_bready  out  1

## Operation
- States: IDLE, AR, R, AWW, B, RESP.
- IDLE: on req_valid, latch addr, size, unsigned, we and wdata. Then:
  - misaligned (half with addr[0]=1; word with addr[1:0]≠0; size 3) -> RESP with err=1 and no AXI traffic;
  - load -> AR;
  - store -> AWW.
- AR: axi_arvalid=1, axi_araddr={addr[31:2],2'b00}. On arready -> R.
- R: axi_rready=1. On rvalid, lane = rdata >> (8*addr[1:0]); byte/half extended per req_unsigned; err=rresp[1]; -> RESP.
- AWW: axi_awvalid and axi_wvalid both raised on entry. Each drops independently after its own handshake. When both handshakes are done -> B. Either channel may complete first, or both in the same cycle.
  - awaddr is word-aligned.
  - wdata: byte replicated ×4, half ×2, word as is.
  - wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- B: axi_bready=1. On bvalid, err=bresp[1]; -> RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_data/resp_err; -> IDLE. If err=1, resp_data=0.
- axi_arprot = axi_awprot = 3'b000 always.
- xVALID signals never drop before their handshake. Address and data stay stable while valid is high.

## Timing
- Reset (asynchronous): state IDLE. All AXI valid/ready outputs 0, all AXI address/data/strb outputs 0, resp_valid=0, resp_data=0, resp_err=0. req_ready=1 (IDLE).
- Reset asserted mid-transaction aborts it immediately: outputs go to reset values and no response is produced.
- All outputs are registered except req_ready, which decodes state.
- Request accepted at edge E0. AR/AWW outputs are visible after E0.
- Load latency with zero-wait slave (arready=1 immediately, rvalid the cycle after rready): resp_valid in the 3rd cycle after E0. Each slave wait cycle adds 1.
- Store latency with zero-wait slave: resp_valid in the 3rd cycle after E0.
- Misaligned access: resp_valid in the 1st cycle after E0.
- req_ready is low from E0 until the edge leaving RESP. Back-to-back throughput is one request per (latency+1) cycles.

## Test plan
- Load word 0x0000_1004, slave returns 0xDEAD_BEEF, rresp=0 -> araddr=0x0000_1004, resp_data=0xDEAD_BEEF, err=0, resp_valid pulse exactly 1 cycle.
- Load byte signed at 0x0000_1007, rdata=0x80FF_0000 -> resp_data=0xFFFF_FF80. Same load unsigned -> 0x0000_0080.
- Store half 0x1234 at 0x0000_100A -> awaddr=0x0000_1008, wdata=0x1234_1234, wstrb=4'b1100, bresp=0 -> err=0, resp_data=0.
- Store word with slave accepting W 2 cycles before AW, then bvalid after 3 cycles -> wvalid drops after its handshake, awvalid holds until awready, exactly one response.
- Load word at 0x0000_1002 -> no arvalid ever asserted, resp_err=1 one cycle after accept. Load with rresp=2'b10 -> resp_err=1, resp_data=0.
- rstn pulled low while in R with rvalid pending -> outputs at reset values asynchronously, no resp_valid. After release, a new request completes normally.

Source files
------------

// File: rtl/mem_axi_master.sv
// mem_axi_master: turns single core load/store requests into AXI4-Lite read or write transactions, one in flight.
// Latency: a misaligned access responds 1 cycle after accept. A load or store with a zero-wait slave responds 3 cycles
//   after accept. Each slave wait cycle adds one cycle.
// Backpressure: req_ready is high only in IDLE. Every AXI valid holds until its own handshake.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   req_*                      core request (valid/ready, we, addr, right-aligned wdata, size, unsigned)
//   resp_valid/data/err        one-cycle completion with extended load data
//   axi_ar*/r*/aw*/w*/b*       AXI4-Lite master channels
module mem_axi_master (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  output logic [2:0]  axi_arprot,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  output logic [2:0]  axi_awprot,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic [1:0]  axi_bresp,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

  state_t      state;
  logic [1:0]  addr_lo;
  logic [1:0]  size_q;
  logic        unsigned_q;

  logic        misaligned;
  logic [31:0] wdata_rep;
  logic [3:0]  wstrb_calc;
  logic [31:0] lane;
  logic [31:0] load_data;

  // Only xRESP[1] (SLVERR/DECERR) signals an error; OKAY and EXOKAY both succeed.
  logic        unused_resp_lsb;
  assign unused_resp_lsb = axi_rresp[0] ^ axi_bresp[0];

  assign req_ready  = (state == IDLE);
  assign axi_arprot = 3'b000;
  assign axi_awprot = 3'b000;

  // Size 3 is reserved, so it is rejected the same way as a misaligned access.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Replicate narrow store data into every lane so the strobe alone selects the target bytes.
  always_comb begin
    wdata_rep  = req_wdata;
    wstrb_calc = 4'b1111;
    case (req_size)
      2'd0: begin
        wdata_rep  = {4{req_wdata[7:0]}};
        wstrb_calc = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        wdata_rep  = {2{req_wdata[15:0]}};
        wstrb_calc = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        wdata_rep  = req_wdata;
        wstrb_calc = 4'b1111;
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then extend it to 32 bits.
  assign lane = axi_rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = lane;
    case (size_q)
      2'd0:    load_data = unsigned_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'd1:    load_data = unsigned_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      addr_lo     <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= 32'b0;
      resp_err    <= 1'b0;
      axi_araddr  <= 32'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      axi_awaddr  <= 32'b0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= 32'b0;
      axi_wstrb   <= 4'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_lo    <= req_addr[1:0];
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_data  <= 32'b0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (!req_we) begin
              axi_araddr  <= {req_addr[31:2], 2'b00};
              axi_arvalid <= 1'b1;
              state       <= AR;
            end else begin
              axi_awaddr  <= {req_addr[31:2], 2'b00};
              axi_awvalid <= 1'b1;
              axi_wdata   <= wdata_rep;
              axi_wstrb   <= wstrb_calc;
              axi_wvalid  <= 1'b1;
              state       <= AWW;
            end
          end
        end
        AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= R;
          end
        end
        R: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi_rresp[1];
            resp_data  <= axi_rresp[1] ? 32'b0 : load_data;
            state      <= RESP;
          end
        end
        AWW: begin
          // AW and W retire independently. A low valid means that channel has already completed.
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
            axi_bready <= 1'b1;
            state      <= B;
          end
        end
        B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= axi_bresp[1];
            resp_data  <= 32'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_master.sv
// tb_mem_axi_master: drives core requests and acts as a configurable-latency AXI4-Lite slave.
// Latency: outputs are sampled on the falling edge, and latency is counted in cycles after the accept edge.
// Backpressure: slave ready/valid waits are set per transaction by the vector or by random stimulus.
module tb_mem_axi_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
  logic        axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
  logic [2:0]  axi_arprot, axi_awprot;
  logic [3:0]  axi_wstrb;
  logic        axi_arready = 1'b0, axi_rvalid = 1'b0, axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic [31:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = '0, axi_bresp = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_axi_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          arw, rw, aww, ww, bw;   // slave wait cycles per channel
  } stim_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    bit          axi;                     // any AXI traffic expected
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  function automatic stim_t st(bit we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size, bit uns,
                               logic [31:0] rdata, logic [1:0] resp, int arw, int rw, int aww, int ww, int bw);
    stim_t s;
    s.we = we; s.addr = addr; s.wdata = wdata; s.size = size; s.uns = uns;
    s.rdata = rdata; s.resp = resp; s.arw = arw; s.rw = rw; s.aww = aww; s.ww = ww; s.bw = bw;
    return s;
  endfunction

  function automatic exp_t ex(logic [31:0] data, bit err, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] wstrb, int lat, bit axi);
    exp_t e;
    e.data = data; e.err = err; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.lat = lat; e.axi = axi;
    return e;
  endfunction

  // Reference model: byte arithmetic on the request, independent of any state-machine structure.
  function automatic exp_t model(stim_t s);
    exp_t        e;
    int unsigned off, nbytes;
    logic [31:0] val;
    e = ex(32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
    off    = s.addr % 4;
    nbytes = 1 << s.size;
    if (s.size == 2'd3 || (s.addr % nbytes) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    e.axi  = 1'b1;
    e.addr = s.addr - off;
    e.err  = (s.resp >= 2);
    if (!s.we) begin
      e.lat = 3 + s.arw + s.rw;
      val = s.rdata >> (off * 8);
      if (s.size == 2'd0) begin
        val = val % 256;
        if (!s.uns && val >= 128) val = val - 256;
      end else if (s.size == 2'd1) begin
        val = val % 65536;
        if (!s.uns && val >= 32768) val = val - 65536;
      end
      e.data = e.err ? 32'h0 : val;
    end else begin
      e.lat   = 3 + ((s.aww > s.ww) ? s.aww : s.ww) + s.bw;
      e.wstrb = 4'(((1 << nbytes) - 1) << off);
      if (s.size == 2'd0)      e.wdata = (s.wdata % 256) * 32'h0101_0101;
      else if (s.size == 2'd1) e.wdata = (s.wdata % 65536) * 32'h0001_0001;
      else                     e.wdata = s.wdata;
    end
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and play the slave cycle by cycle, checking protocol rules along the way.
  task automatic run_txn(input int id, input stim_t s, input exp_t e);
    int          cyc, lat, resp_cnt, viol, r_seen, b_seen, r_hs, b_hs;
    int          seen[3], hs[3], wt[3];
    bit          v[3], pv[3], rdy[3], prev_rready, prev_bready, done;
    logic [35:0] p[3], pp[3], cap[3];
    logic [31:0] got_data;
    logic        got_err;
    cyc = 0; lat = 0; resp_cnt = 0; viol = 0; r_seen = 0; b_seen = 0; r_hs = 0; b_hs = 0;
    prev_rready = 0; prev_bready = 0; done = 0; got_data = '0; got_err = 1'b0;
    wt[0] = s.arw; wt[1] = s.aww; wt[2] = s.ww;
    for (int c = 0; c < 3; c++) begin
      seen[c] = 0; hs[c] = 0; v[c] = 0; pv[c] = 0; rdy[c] = 0; p[c] = '0; pp[c] = '0; cap[c] = '0;
    end
    @(negedge clk);
    chk($sformatf("t%0d req_ready before", id), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = s.we; req_addr = s.addr; req_wdata = s.wdata;
    req_size = s.size; req_unsigned = s.uns;
    axi_rdata = s.rdata; axi_rresp = s.resp; axi_bresp = s.resp;
    @(posedge clk);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      v[0] = axi_arvalid; p[0] = {4'h0, axi_araddr};
      v[1] = axi_awvalid; p[1] = {4'h0, axi_awaddr};
      v[2] = axi_wvalid;  p[2] = {axi_wstrb, axi_wdata};
      for (int c = 0; c < 3; c++) begin
        if (rdy[c] && pv[c]) hs[c]++;
        else if (pv[c] && (!v[c] || p[c] !== pp[c])) viol++;
        if (v[c]) begin
          if (hs[c] > 0) viol++;
          seen[c]++;
          cap[c] = p[c];
        end
        rdy[c] = v[c] && (seen[c] > wt[c]);
        pv[c] = v[c];
        pp[c] = p[c];
      end
      axi_arready = rdy[0]; axi_awready = rdy[1]; axi_wready = rdy[2];
      if (axi_rvalid && prev_rready) r_hs++;
      if (axi_rready) r_seen++;
      axi_rvalid = axi_rready && (r_seen > s.rw) && (r_hs == 0);
      prev_rready = axi_rready;
      if (axi_bvalid && prev_bready) b_hs++;
      if (axi_bready) b_seen++;
      axi_bvalid = axi_bready && (b_seen > s.bw) && (b_hs == 0);
      prev_bready = axi_bready;
      if (resp_valid) begin
        if (resp_cnt == 0) begin
          got_data = resp_data; got_err = resp_err; lat = cyc;
        end
        resp_cnt++;
      end else if (resp_cnt > 0) begin
        done = 1;
      end
      if (req_ready && !done) viol++;
    end
    axi_arready = 0; axi_awready = 0; axi_wready = 0; axi_rvalid = 0; axi_bvalid = 0;
    chk($sformatf("t%0d completed in budget", id), 32'(done), 32'd1);
    chk($sformatf("t%0d resp pulse width", id), 32'(resp_cnt), 32'd1);
    chk($sformatf("t%0d resp_data", id), got_data, e.data);
    chk($sformatf("t%0d resp_err", id), 32'(got_err), 32'(e.err));
    chk($sformatf("t%0d latency", id), 32'(lat), 32'(e.lat));
    chk($sformatf("t%0d protocol violations", id), 32'(viol), 32'd0);
    chk($sformatf("t%0d req_ready after", id), 32'(req_ready), 32'd1);
    if (!e.axi) begin
      chk($sformatf("t%0d no axi valid", id), 32'(seen[0] + seen[1] + seen[2] + r_seen + b_seen), 32'd0);
    end else if (!s.we) begin
      chk($sformatf("t%0d ar/r handshakes", id), 32'(hs[0] * 16 + r_hs), 32'h11);
      chk($sformatf("t%0d no write traffic", id), 32'(seen[1] + seen[2] + b_seen), 32'd0);
      chk($sformatf("t%0d araddr", id), cap[0][31:0], e.addr);
    end else begin
      chk($sformatf("t%0d aw/w/b handshakes", id), 32'(hs[1] * 256 + hs[2] * 16 + b_hs), 32'h111);
      chk($sformatf("t%0d no read traffic", id), 32'(seen[0] + r_seen), 32'd0);
      chk($sformatf("t%0d awaddr", id), cap[1][31:0], e.addr);
      chk($sformatf("t%0d wdata", id), cap[2][31:0], e.wdata);
      chk($sformatf("t%0d wstrb", id), 32'(cap[2][35:32]), 32'(e.wstrb));
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " resp"}, {resp_data[30:0], resp_valid}, 32'd0);
    chk({tag, " resp_err/data31"}, 32'({resp_err, resp_data[31]}), 32'd0);
    chk({tag, " valids/readies"}, 32'({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}), 32'd0);
    chk({tag, " araddr"}, axi_araddr, 32'd0);
    chk({tag, " awaddr"}, axi_awaddr, 32'd0);
    chk({tag, " wdata"}, axi_wdata, 32'd0);
    chk({tag, " wstrb/prot"}, 32'({axi_wstrb, axi_arprot, axi_awprot}), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    stim_t s;
    int    pulses;

    tbl.push_back('{st(0, 32'h1004, 0, 2, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0), ex(32'hDEAD_BEEF, 0, 32'h1004, 0, 0, 3, 1)});
    tbl.push_back('{st(0, 32'h1007, 0, 0, 0, 32'h80FF_0000, 0, 0, 0, 0, 0, 0), ex(32'hFFFF_FF80, 0, 32'h1004, 0, 0, 3, 1)});
    tbl.push_back('{st(0, 32'h1007, 0, 0, 1, 32'h80FF_0000, 0, 0, 0, 0, 0, 0), ex(32'h0000_0080, 0, 32'h1004, 0, 0, 3, 1)});
    tbl.push_back('{st(1, 32'h100A, 32'hABCD_1234, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 32'h1008, 32'h1234_1234, 4'b1100, 3, 1)});
    tbl.push_back('{st(1, 32'h2000, 32'hCAFE_F00D, 2, 0, 0, 0, 0, 0, 2, 0, 3), ex(0, 0, 32'h2000, 32'hCAFE_F00D, 4'b1111, 8, 1)});
    tbl.push_back('{st(0, 32'h1002, 0, 2, 0, 32'h5555_5555, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 1, 0)});
    tbl.push_back('{st(0, 32'h1010, 0, 2, 0, 32'h1234_5678, 2, 0, 0, 0, 0, 0), ex(0, 1, 32'h1010, 0, 0, 3, 1)});
    tbl.push_back('{st(1, 32'h3003, 32'h0000_00A5, 0, 0, 0, 3, 0, 0, 0, 0, 0), ex(0, 1, 32'h3000, 32'hA5A5_A5A5, 4'b1000, 3, 1)});
    tbl.push_back('{st(0, 32'h1006, 0, 1, 0, 32'h9ABC_0000, 0, 1, 2, 0, 0, 0), ex(32'hFFFF_9ABC, 0, 32'h1004, 0, 0, 6, 1)});
    tbl.push_back('{st(0, 32'h1000, 0, 3, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 1, 0)});
    tbl.push_back('{st(1, 32'h1001, 32'h0000_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 1, 0, 0, 0, 1, 0)});
    tbl.push_back('{st(1, 32'h4004, 32'h1122_3344, 2, 0, 0, 1, 0, 0, 0, 2, 0), ex(0, 0, 32'h4004, 32'h1122_3344, 4'b1111, 5, 1)});
    tbl.push_back('{st(0, 32'h1002, 0, 1, 1, 32'h8001_0000, 0, 0, 0, 0, 0, 0), ex(32'h0000_8001, 0, 32'h1000, 0, 0, 3, 1)});
    tbl.push_back('{st(0, 32'h1001, 0, 0, 0, 32'h0000_7F00, 0, 0, 0, 0, 0, 0), ex(32'h0000_007F, 0, 32'h1000, 0, 0, 3, 1)});
    tbl.push_back('{st(1, 32'h5001, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 1, 1, 1), ex(0, 0, 32'h5000, 32'h3434_3434, 4'b0010, 5, 1)});

    // Reset state, then release on a falling edge.
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_txn(i, tbl[i].s, tbl[i].e);

    // Reset pulled low while the slave has rvalid pending in R.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1008; req_size = 2'd2; req_unsigned = 1'b0;
    axi_rdata = 32'h7777_7777; axi_rresp = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort arvalid before", 32'(axi_arvalid), 32'd1);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    chk("abort rready before", 32'(axi_rready), 32'd1);
    axi_rvalid = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk_reset_outputs("abort async");
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    chk("abort no response", 32'(pulses), 32'd0);
    axi_rvalid = 1'b0;
    rstn = 1'b1;
    run_txn(100, tbl[0].s, tbl[0].e);
    run_txn(101, tbl[3].s, tbl[3].e);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      s.we    = 1'($urandom_range(0, 1));
      s.size  = 2'($urandom_range(0, 3));
      s.addr  = 32'h1000_0000 + ($urandom & 32'h0000_FFFF);
      if ($urandom_range(0, 2) != 0) s.addr = s.addr & ~((32'd1 << s.size) - 32'd1);
      s.wdata = $urandom;
      s.uns   = 1'($urandom_range(0, 1));
      s.rdata = $urandom;
      s.resp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s.arw   = $urandom_range(0, 3);
      s.rw    = $urandom_range(0, 3);
      s.aww   = $urandom_range(0, 3);
      s.ww    = $urandom_range(0, 3);
      s.bw    = $urandom_range(0, 3);
      run_txn(200 + i, s, model(s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
